// File: rtl/str_vga_sink_if.sv
// Stream VGA bus: packed timing/coordinate word plus the colour for the same pixel.
interface str_vga_sink_if #(
  parameter int CW = 4
);
  logic [22:0]     strVGA;
  logic [3*CW-1:0] rgb_in;

  modport master (output strVGA, output rgb_in);
  modport slave  (input  strVGA, input  rgb_in);
endinterface

// File: rtl/str_vga_sink.sv
// Consumer end of the stream VGA bus: registers pin signals, blanks colour,
// and tracks timing continuity to report lock and violations.
module str_vga_sink #(
  parameter int   H_TOTAL   = 800,
  parameter int   V_TOTAL   = 525,
  parameter int   H_ACTIVE  = 640,
  parameter int   V_ACTIVE  = 480,
  parameter int   LOCK_FRMS = 2,
  parameter int   CW        = 4,
  parameter logic SYNC_IDLE = 1'b1
) (
  input  logic            px_clk,
  input  logic            reset,
  str_vga_sink_if.slave   bus,
  output logic [9:0]      x_px,
  output logic [9:0]      y_px,
  output logic            hsync_o,
  output logic            vsync_o,
  output logic [3*CW-1:0] rgb_o,
  output logic            locked,
  output logic            err,
  output logic [7:0]      err_cnt,
  output logic [15:0]     frame_cnt
);
  localparam int         FC_W     = $clog2(LOCK_FRMS + 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_TOT10  = 10'(H_TOTAL);
  localparam logic [9:0] V_TOT10  = 10'(V_TOTAL);
  localparam logic [9:0] H_ACT10  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT10  = 10'(V_ACTIVE);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(LOCK_FRMS - 1);

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  state_t          state_reg, state_next;
  logic [FC_W-1:0] fc_reg, fc_next;
  logic            prev_valid_reg;

  logic            av_in, vs_in, hs_in;
  logic [9:0]      x_in, y_in;
  logic [9:0]      x_exp, y_exp;
  logic            range_bad, av_bad, cont_bad, viol, fs;
  logic [3*CW-1:0] rgb_gated;

  assign {av_in, vs_in, hs_in, y_in, x_in} = bus.strVGA;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      assign rgb_gated[gi*CW +: CW] = av_in ? bus.rgb_in[gi*CW +: CW] : '0;
    end
  endgenerate

  // The registered coordinate outputs double as the previous-cycle position.
  always_comb begin
    x_exp = (x_px == H_LAST) ? 10'd0 : x_px + 10'd1;
    y_exp = y_px;
    if (x_px == H_LAST) begin
      y_exp = (y_px == V_LAST) ? 10'd0 : y_px + 10'd1;
    end
    range_bad = (x_in >= H_TOT10) || (y_in >= V_TOT10);
    av_bad    = av_in != ((x_in < H_ACT10) && (y_in < V_ACT10));
    cont_bad  = prev_valid_reg && ((x_in != x_exp) || (y_in != y_exp));
    viol      = range_bad || av_bad || cont_bad;
    fs        = (x_in == 10'd0) && (y_in == 10'd0);
  end

  always_ff @(posedge px_clk) begin
    if (reset) begin
      x_px           <= '0;
      y_px           <= '0;
      hsync_o        <= SYNC_IDLE;
      vsync_o        <= SYNC_IDLE;
      rgb_o          <= '0;
      err            <= 1'b0;
      err_cnt        <= '0;
      frame_cnt      <= '0;
      prev_valid_reg <= 1'b0;
    end else begin
      x_px           <= x_in;
      y_px           <= y_in;
      hsync_o        <= hs_in;
      vsync_o        <= vs_in;
      rgb_o          <= rgb_gated;
      err            <= viol;
      if (viol && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
      if (fs) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      prev_valid_reg <= 1'b1;
    end
  end

  always_ff @(posedge px_clk) begin
    if (reset) begin
      state_reg <= SEARCH;
      fc_reg    <= '0;
    end else begin
      state_reg <= state_next;
      fc_reg    <= fc_next;
    end
  end

  // A violation wins over a simultaneous frame start.
  always_comb begin
    state_next = state_reg;
    fc_next    = fc_reg;
    if (viol) begin
      state_next = SEARCH;
      fc_next    = '0;
    end else begin
      case (state_reg)
        SEARCH: begin
          if (fs) begin
            state_next = ALIGN;
            fc_next    = '0;
          end
        end
        ALIGN: begin
          if (fs) begin
            if (fc_reg == FC_LAST) begin
              state_next = LOCKED;
            end else begin
              fc_next = fc_reg + FC_W'(1);
            end
          end
        end
        LOCKED: begin
          state_next = LOCKED;
        end
        default: begin
          state_next = SEARCH;
          fc_next    = '0;
        end
      endcase
    end
  end

  always_comb begin
    locked = 1'b0;
    if (state_reg == LOCKED) begin
      locked = 1'b1;
    end
  end
endmodule

// File: tb/tb_str_vga_sink.sv
// Randomized bench for str_vga_sink on a scaled-down raster, checked against
// a frame-counting reference model.
module tb_str_vga_sink;
  localparam int H  = 24;
  localparam int V  = 10;
  localparam int HA = 16;
  localparam int VA = 6;
  localparam int LF = 2;
  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  x_px, y_px;
  logic        hsync_o, vsync_o;
  logic [11:0] rgb_o;
  logic        locked, err;
  logic [7:0]  err_cnt;
  logic [15:0] frame_cnt;

  str_vga_sink_if #(.CW(CW)) bus ();

  str_vga_sink #(
    .H_TOTAL(H), .V_TOTAL(V), .H_ACTIVE(HA), .V_ACTIVE(VA),
    .LOCK_FRMS(LF), .CW(CW), .SYNC_IDLE(1'b1)
  ) dut (
    .px_clk(clk), .reset(reset), .bus(bus),
    .x_px(x_px), .y_px(y_px), .hsync_o(hsync_o), .vsync_o(vsync_o),
    .rgb_o(rgb_o), .locked(locked), .err(err), .err_cnt(err_cnt),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: lock = LF+1 clean frame starts since the last break.
  logic        m_prev_valid;
  int          m_px, m_py, m_clean;
  logic [9:0]  e_x, e_y;
  logic        e_hs, e_vs, e_locked, e_err;
  logic [11:0] e_rgb;
  logic [7:0]  e_err_cnt;
  logic [15:0] e_frame_cnt;
  int          cur_x, cur_y;

  function automatic logic [59:0] dut_vec();
    return {x_px, y_px, hsync_o, vsync_o, rgb_o, locked, err, err_cnt, frame_cnt};
  endfunction

  function automatic logic [59:0] exp_vec();
    return {e_x, e_y, e_hs, e_vs, e_rgb, e_locked, e_err, e_err_cnt, e_frame_cnt};
  endfunction

  function automatic logic hs_of(input int x);
    return !((x >= HA + 2) && (x < HA + 5));
  endfunction

  function automatic logic vs_of(input int y);
    return !(y == VA + 1);
  endfunction

  task automatic drive(input logic av, input logic vs, input logic hs, input int x,
                       input int y, input logic [11:0] rgb, input logic rst);
    logic viol, fs;
    int   xe, ye;
    reset      = rst;
    bus.strVGA = {av, vs, hs, 10'(y), 10'(x)};
    bus.rgb_in = rgb;
    @(posedge clk);
    #1;
    if (rst) begin
      e_x = '0; e_y = '0; e_hs = 1'b1; e_vs = 1'b1; e_rgb = '0;
      e_err = 1'b0; e_err_cnt = '0; e_frame_cnt = '0; e_locked = 1'b0;
      m_prev_valid = 1'b0; m_clean = 0;
    end else begin
      fs   = (x == 0) && (y == 0);
      viol = (x >= H) || (y >= V) || (av != ((x < HA) && (y < VA)));
      if (m_prev_valid) begin
        xe = (m_px == H - 1) ? 0 : m_px + 1;
        ye = m_py;
        if (m_px == H - 1) ye = (m_py == V - 1) ? 0 : m_py + 1;
        if ((x != xe) || (y != ye)) viol = 1'b1;
      end
      e_x = 10'(x); e_y = 10'(y); e_hs = hs; e_vs = vs;
      e_rgb = av ? rgb : 12'h000;
      e_err = viol;
      if (viol && (e_err_cnt != 8'd255)) e_err_cnt = e_err_cnt + 8'd1;
      if (fs) e_frame_cnt = e_frame_cnt + 16'd1;
      if (viol) m_clean = 0;
      else if (fs) m_clean++;
      e_locked = (m_clean >= LF + 1);
      m_prev_valid = 1'b1; m_px = x; m_py = y;
    end
  endtask

  task automatic advance();
    cur_x++;
    if (cur_x >= H) begin
      cur_x = 0;
      cur_y = (cur_y + 1) % V;
    end
  endtask

  task automatic drive_cur(input logic [11:0] rgb);
    drive(logic'((cur_x < HA) && (cur_y < VA)), vs_of(cur_y), hs_of(cur_x),
          cur_x, cur_y, rgb, 1'b0);
    advance();
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 5, 7, 12'hFFF, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 9, 3, 12'h123, 1'b1);
    checks++;
    if ({hsync_o, vsync_o} !== 2'b11) begin
      errors++; $display("FAIL reset_sync got %b want 11", {hsync_o, vsync_o});
    end
    checks++;
    if ({x_px, y_px, rgb_o, locked, err, err_cnt, frame_cnt} !== 58'd0) begin
      errors++; $display("FAIL reset_zero got %h want 0",
                         {x_px, y_px, rgb_o, locked, err, err_cnt, frame_cnt});
    end
    cur_x = 0;
    cur_y = 0;
    $display("test_reset done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_lock();
    int   fs_seen = 0;
    logic done = 1'b0;
    for (int i = 0; (i < 3 * H * V + 5) && !done; i++) begin
      logic was_fs;
      was_fs = (cur_x == 0) && (cur_y == 0);
      drive_cur(12'($urandom));
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        if (errors <= 20) $display("FAIL lock_stream cyc %0d got %h want %h", i, dut_vec(), exp_vec());
      end
      if (was_fs) begin
        fs_seen++;
        if (fs_seen == LF + 1) begin
          checks++;
          if ((locked !== 1'b1) || (frame_cnt !== 16'd3) || (err_cnt !== 8'd0)) begin
            errors++;
            $display("FAIL lock_rise got locked=%b frame_cnt=%0d err_cnt=%0d want 1/3/0",
                     locked, frame_cnt, err_cnt);
          end
          done = 1'b1;
        end else begin
          checks++;
          if (locked !== 1'b0) begin
            errors++; $display("FAIL lock_early got %b want 0 at fs %0d", locked, fs_seen);
          end
        end
      end
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL lock_budget got %0d frame starts want %0d", fs_seen, LF + 1);
    end
    $display("test_lock done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_colour();
    for (int i = 0; (i < H * V) && !((cur_x == HA - 1) && (cur_y == 1)); i++) begin
      drive_cur(12'($urandom));
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        if (errors <= 20) $display("FAIL colour_seek got %h want %h", dut_vec(), exp_vec());
      end
    end
    drive_cur(12'hABC);
    checks++;
    if (rgb_o !== 12'hABC) begin
      errors++; $display("FAIL colour_active got %h want abc", rgb_o);
    end
    drive_cur(12'h5A5);
    checks++;
    if (rgb_o !== 12'h000) begin
      errors++; $display("FAIL colour_blank got %h want 000", rgb_o);
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL colour_vec got %h want %h", dut_vec(), exp_vec());
    end
    $display("test_colour done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_jump();
    for (int i = 0; (i < H) && (cur_x != 10); i++) drive_cur(12'($urandom));
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL jump_pre got locked=%b want 1", locked);
    end
    drive_cur(12'($urandom));
    advance();
    drive_cur(12'($urandom));
    checks++;
    if ((err !== 1'b1) || (err_cnt !== 8'd1) || (locked !== 1'b0)) begin
      errors++; $display("FAIL jump_err got err=%b err_cnt=%0d locked=%b want 1/1/0",
                         err, err_cnt, locked);
    end
    drive_cur(12'($urandom));
    checks++;
    if ((err !== 1'b0) || (locked !== 1'b0)) begin
      errors++; $display("FAIL jump_after got err=%b locked=%b want 0/0", err, locked);
    end
    $display("test_jump done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_relock();
    int   fs_seen = 0;
    logic done = 1'b0;
    for (int i = 0; (i < 4 * H * V) && !done; i++) begin
      logic was_fs;
      was_fs = (cur_x == 0) && (cur_y == 0);
      drive_cur(12'($urandom));
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        if (errors <= 20) $display("FAIL relock_stream got %h want %h", dut_vec(), exp_vec());
      end
      if (was_fs) fs_seen++;
      if (was_fs && (fs_seen == LF + 1)) begin
        checks++;
        if (locked !== 1'b1) begin
          errors++; $display("FAIL relock_rise got %b want 1", locked);
        end
        done = 1'b1;
      end else begin
        checks++;
        if (locked !== 1'b0) begin
          errors++; $display("FAIL relock_early got %b want 0 after %0d fs", locked, fs_seen);
        end
      end
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL relock_budget got %0d frame starts want %0d", fs_seen, LF + 1);
    end
    $display("test_relock done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_av_force();
    for (int i = 0; (i < H * V) && !((cur_x == 20) && (cur_y == 5)); i++) begin
      drive_cur(12'($urandom));
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        if (errors <= 20) $display("FAIL av_seek got %h want %h", dut_vec(), exp_vec());
      end
    end
    drive(1'b1, vs_of(5), hs_of(20), 20, 5, 12'h777, 1'b0);
    advance();
    checks++;
    if ((err !== 1'b1) || (err_cnt !== 8'd2) || (locked !== 1'b0) || (rgb_o !== 12'h777)) begin
      errors++; $display("FAIL av_force got err=%b err_cnt=%0d locked=%b rgb=%h want 1/2/0/777",
                         err, err_cnt, locked, rgb_o);
    end
    drive_cur(12'($urandom));
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL av_after got err=%b want 0", err);
    end
    $display("test_av_force done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        advance();
        drive_cur(12'($urandom));
      end else if (r < 4) begin
        drive(logic'(!((cur_x < HA) && (cur_y < VA))), vs_of(cur_y), hs_of(cur_x),
              cur_x, cur_y, 12'($urandom), 1'b0);
        advance();
      end else if (r < 5) begin
        drive(1'b0, vs_of(cur_y), 1'b1, H + $urandom_range(0, 5), cur_y, 12'($urandom), 1'b0);
        advance();
      end else if (r < 6) begin
        drive(1'b0, 1'b1, hs_of(cur_x), cur_x, V + $urandom_range(0, 3), 12'($urandom), 1'b0);
        advance();
      end else begin
        drive_cur(12'($urandom));
      end
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        if (errors <= 20) $display("FAIL random cyc %0d got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    $display("test_random done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_mid_reset();
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL midrst_pre got locked=%b want 1", locked);
    end
    for (int i = 0; (i < H * V) && !((cur_x == 5) && (cur_y == 4)); i++) begin
      drive_cur(12'($urandom));
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        if (errors <= 20) $display("FAIL midrst_seek got %h want %h", dut_vec(), exp_vec());
      end
    end
    drive(1'b1, vs_of(cur_y), hs_of(cur_x), cur_x, cur_y, 12'hFFF, 1'b1);
    advance();
    checks++;
    if ((locked !== 1'b0) || (rgb_o !== 12'h000) || ({hsync_o, vsync_o} !== 2'b11) ||
        (err_cnt !== 8'd0) || (frame_cnt !== 16'd0) || (err !== 1'b0) ||
        (x_px !== 10'd0) || (y_px !== 10'd0)) begin
      errors++; $display("FAIL midrst_state got %h want reset values", dut_vec());
    end
    $display("test_mid_reset done checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      drive(logic'(!((cur_x < HA) && (cur_y < VA))), vs_of(cur_y), hs_of(cur_x),
            cur_x, cur_y, 12'($urandom), 1'b0);
      advance();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        if (errors <= 20) $display("FAIL saturate_stream got %h want %h", dut_vec(), exp_vec());
      end
    end
    checks++;
    if ((err_cnt !== 8'd255) || (err !== 1'b1) || (locked !== 1'b0)) begin
      errors++; $display("FAIL saturate got err_cnt=%0d err=%b locked=%b want 255/1/0",
                         err_cnt, err, locked);
    end
    $display("test_saturate done checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_colour();
    test_jump();
    test_relock();
    test_av_force();
    test_random();
    test_relock();
    test_mid_reset();
    test_relock();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
